rect_draw_engine: RTL and testbench
===================================

Name: rect_draw_engine

Overview:
Parametrised, command-driven pixel generator that replaces the fixed draw block feeding VGA_Ctrl's write_x/write_y/write_r/write_g/write_b port. It accepts one rectangle command at a time (fill, outline or clear-screen) and streams pixel writes in raster order. Coordinate width, colour depth and screen bounds are parametrised. A valid/ready handshake toward the framebuffer and a start/busy/done handshake toward the host are new behaviour.

Parameters:
XW, 8, X coordinate width
YW, 8, Y coordinate width
CW, 3, per-channel colour width
XMAX, 159, last valid screen column (must fit XW)
YMAX, 119, last valid screen row (must fit YW)

Ports:
CLK  in  1  pixel clock (40 MHz domain)
NRST  in  1  synchronous active-low reset
START  in  1  command strobe, sampled in IDLE only
MODE  in  2  00 fill, 01 outline, 10 clear screen, 11 no-op
X0  in  XW  corner A column
Y0  in  YW  corner A row
X1  in  XW  corner B column
Y1  in  YW  corner B row
CR  in  CW  red value
CG  in  CW  green value
CB  in  CW  blue value
WREADY  in  1  framebuffer accepts pixel
BUSY  out  1  command in progress
DONE  out  1  one-cycle completion pulse
X  out  XW  pixel column
Y  out  YW  pixel row
R  out  CW  pixel red
G  out  CW  pixel green
B  out  CW  pixel blue
WE  out  1  pixel valid

Behaviour:
- Reset (NRST=0 at CLK edge): state IDLE; X, Y, R, G, B, WE, BUSY, DONE all 0. Reset mid-command aborts immediately, with no DONE and no further WE.
- States: IDLE, SETUP, SCAN, FINISH.
- IDLE: START=1 latches MODE, coordinates and colour, then goes to SETUP; BUSY=1 from the next cycle.
- SETUP, one cycle:
  - xl=min(X0,X1), xh=max(X0,X1); same for yl/yh.
  - Clamp each of xl/xh to XMAX and each of yl/yh to YMAX.
  - Clear mode: xl=0, xh=XMAX, yl=0, yh=YMAX.
  - MODE=11: go to FINISH. All other modes: load x=xl, y=yl, then go to SCAN.
- SCAN:
  - WE=1 with X=x, Y=y and R/G/B equal to the latched colour.
  - Pixel is accepted on a cycle with WE=1 and WREADY=1. While WREADY=0, X/Y/R/G/B/WE hold unchanged.
  - On accept, advance in raster order, x fastest: if x<xh then x+1, else x=xl and y+1.
  - Last pixel (x=xh, y=yh) accepted: go to FINISH, WE=0 next cycle.
  - Throughput is 1 pixel/cycle while WREADY=1. First WE appears 2 cycles after the START cycle.
- Outline mode:
  - Emit only pixels with x∈{xl,xh} or y∈{yl,yh}.
  - On interior rows (yl<y<yh), accepting x=xl jumps directly to x=xh. No idle cycles, no interior pixels.
  - Degenerate cases (xl=xh or yl=yh): every pixel is emitted exactly once, never twice.
- FINISH, one cycle: DONE=1, BUSY=1, WE=0; then IDLE with BUSY=0.
- START while BUSY=1 (SETUP/SCAN/FINISH) is ignored and not queued.
- Latched command inputs may change freely after the START cycle.
- Counters sized XW/YW; no wrap occurs because clamping guarantees x≤XMAX and y≤YMAX.
- Pixel count:
  - fill: (xh-xl+1)(yh-yl+1)
  - outline: 2w+2h-4 for w,h≥2; w·h otherwise
  - clear: (XMAX+1)(YMAX+1)
- Single clock domain; no combinational path from WREADY to WE. X/Y may update combinationally only via registered state.

Test Plan:
1. Fill X0=2 Y0=3 X1=4 Y1=4, CR/CG/CB=5/2/7, WREADY=1:
   - 6 WE cycles: (2,3),(3,3),(4,3),(2,4),(3,4),(4,4), RGB=5/2/7.
   - First WE at START+2; DONE one cycle after the last WE; BUSY low next cycle.
2. Same command with X0=4 X1=2 Y0=4 Y1=3 -> identical pixel sequence.
3. Outline 0,0 to 3,3:
   - Exactly 12 pixels; (1,1),(2,1),(1,2),(2,2) never emitted.
   - Row 1 emits (0,1) then (3,1) on consecutive cycles.
   - Outline 5,5 to 5,8 -> 4 pixels, none duplicated.
4. Backpressure, fill of case 1 with WREADY=1,0,1,0,...:
   - Outputs stable while WREADY=0.
   - Exactly 6 accepts in order, no loss or duplication.
   - START pulsed mid-scan is ignored.
5. Clamp/clear with defaults:
   - Fill X1=200 -> last column 159.
   - Clear with colour 1/1/1 -> 19200 accepts, last (159,119), single DONE.
   - MODE=11 -> no WE, DONE at START+2.
6. Reset mid-op:
   - NRST=0 after 3 accepts -> WE/BUSY/DONE=0 after that edge; no DONE afterwards.
   - New START after release runs the full command correctly.

Source files
------------

// File: rtl/rect_draw_engine_if.sv
// Command and pixel-stream signals of the rectangle draw engine.
// The host drives the command fields and WREADY; the engine drives status and pixel outputs.
interface rect_draw_engine_if #(
  parameter int XW = 8,
  parameter int YW = 8,
  parameter int CW = 3
);
  logic          START;
  logic [1:0]    MODE;
  logic [XW-1:0] X0;
  logic [YW-1:0] Y0;
  logic [XW-1:0] X1;
  logic [YW-1:0] Y1;
  logic [CW-1:0] CR;
  logic [CW-1:0] CG;
  logic [CW-1:0] CB;
  logic          WREADY;
  logic          BUSY;
  logic          DONE;
  logic [XW-1:0] X;
  logic [YW-1:0] Y;
  logic [CW-1:0] R;
  logic [CW-1:0] G;
  logic [CW-1:0] B;
  logic          WE;

  modport master (
    output START, MODE, X0, Y0, X1, Y1, CR, CG, CB, WREADY,
    input  BUSY, DONE, X, Y, R, G, B, WE
  );

  modport slave (
    input  START, MODE, X0, Y0, X1, Y1, CR, CG, CB, WREADY,
    output BUSY, DONE, X, Y, R, G, B, WE
  );
endinterface

// File: rtl/rect_draw_engine.sv
// Command-driven rectangle pixel generator: fill, outline or clear-screen,
// streamed in raster order over a valid/ready pixel handshake.
module rect_draw_engine #(
  parameter int XW   = 8,
  parameter int YW   = 8,
  parameter int CW   = 3,
  parameter int XMAX = 159,
  parameter int YMAX = 119
) (
  input  logic              CLK,
  input  logic              NRST,
  rect_draw_engine_if.slave bus
);

  localparam logic [XW-1:0] X_LAST       = XW'(XMAX);
  localparam logic [YW-1:0] Y_LAST       = YW'(YMAX);
  localparam logic [1:0]    MODE_OUTLINE = 2'b01;
  localparam logic [1:0]    MODE_CLEAR   = 2'b10;
  localparam logic [1:0]    MODE_NOP     = 2'b11;

  typedef enum logic [1:0] {IDLE, SETUP, SCAN, FINISH} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    mode_reg, mode_next;
  logic [XW-1:0] x0_reg, x0_next, x1_reg, x1_next;
  logic [YW-1:0] y0_reg, y0_next, y1_reg, y1_next;
  logic [CW-1:0] r_reg, r_next, g_reg, g_next, b_reg, b_next;
  logic [XW-1:0] xl_reg, xl_next, xh_reg, xh_next;
  logic [YW-1:0] yl_reg, yl_next, yh_reg, yh_next;
  logic [XW-1:0] x_reg, x_next;
  logic [YW-1:0] y_reg, y_next;
  logic          we_reg, we_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;

  logic [XW-1:0] xl_c, xh_c;
  logic [YW-1:0] yl_c, yh_c;
  logic          interior_row;
  logic          last_pix;

  // Normalised, clamped bounds derived from the latched corners.
  always_comb begin
    xl_c = (x0_reg < x1_reg) ? x0_reg : x1_reg;
    xh_c = (x0_reg < x1_reg) ? x1_reg : x0_reg;
    yl_c = (y0_reg < y1_reg) ? y0_reg : y1_reg;
    yh_c = (y0_reg < y1_reg) ? y1_reg : y0_reg;
    if (xl_c > X_LAST) xl_c = X_LAST;
    if (xh_c > X_LAST) xh_c = X_LAST;
    if (yl_c > Y_LAST) yl_c = Y_LAST;
    if (yh_c > Y_LAST) yh_c = Y_LAST;
    if (mode_reg == MODE_CLEAR) begin
      xl_c = '0;
      xh_c = X_LAST;
      yl_c = '0;
      yh_c = Y_LAST;
    end
  end

  assign interior_row = (mode_reg == MODE_OUTLINE) && (y_reg > yl_reg) && (y_reg < yh_reg);
  assign last_pix     = (x_reg == xh_reg) && (y_reg == yh_reg);

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    x0_next    = x0_reg;
    x1_next    = x1_reg;
    y0_next    = y0_reg;
    y1_next    = y1_reg;
    r_next     = r_reg;
    g_next     = g_reg;
    b_next     = b_reg;
    xl_next    = xl_reg;
    xh_next    = xh_reg;
    yl_next    = yl_reg;
    yh_next    = yh_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    we_next    = we_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        we_next   = 1'b0;
        if (bus.START) begin
          mode_next  = bus.MODE;
          x0_next    = bus.X0;
          x1_next    = bus.X1;
          y0_next    = bus.Y0;
          y1_next    = bus.Y1;
          r_next     = bus.CR;
          g_next     = bus.CG;
          b_next     = bus.CB;
          busy_next  = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        xl_next = xl_c;
        xh_next = xh_c;
        yl_next = yl_c;
        yh_next = yh_c;
        if (mode_reg == MODE_NOP) begin
          done_next  = 1'b1;
          state_next = FINISH;
        end else begin
          x_next     = xl_c;
          y_next     = yl_c;
          we_next    = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        // WE is always high here, so WREADY alone marks an accept.
        if (bus.WREADY) begin
          if (last_pix) begin
            we_next    = 1'b0;
            done_next  = 1'b1;
            state_next = FINISH;
          end else if (x_reg < xh_reg) begin
            // Outline interior rows skip straight from the left edge to the right edge.
            x_next = (interior_row && (x_reg == xl_reg)) ? xh_reg : x_reg + 1'b1;
          end else begin
            x_next = xl_reg;
            y_next = y_reg + 1'b1;
          end
        end
      end
      FINISH: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_reg <= IDLE;
      mode_reg  <= '0;
      x0_reg    <= '0;
      x1_reg    <= '0;
      y0_reg    <= '0;
      y1_reg    <= '0;
      r_reg     <= '0;
      g_reg     <= '0;
      b_reg     <= '0;
      xl_reg    <= '0;
      xh_reg    <= '0;
      yl_reg    <= '0;
      yh_reg    <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      we_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      x0_reg    <= x0_next;
      x1_reg    <= x1_next;
      y0_reg    <= y0_next;
      y1_reg    <= y1_next;
      r_reg     <= r_next;
      g_reg     <= g_next;
      b_reg     <= b_next;
      xl_reg    <= xl_next;
      xh_reg    <= xh_next;
      yl_reg    <= yl_next;
      yh_reg    <= yh_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      we_reg    <= we_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // Colour is only shown while a pixel is offered, so reset and idle read as zero.
  assign bus.X    = x_reg;
  assign bus.Y    = y_reg;
  assign bus.R    = we_reg ? r_reg : '0;
  assign bus.G    = we_reg ? g_reg : '0;
  assign bus.B    = we_reg ? b_reg : '0;
  assign bus.WE   = we_reg;
  assign bus.BUSY = busy_reg;
  assign bus.DONE = done_reg;

endmodule

// File: tb/tb_rect_draw_engine.sv
// Randomised bench for rect_draw_engine: each command is expanded into its
// expected pixel list by a loop model and compared accept by accept.
module tb_rect_draw_engine;
  localparam int XW   = 8;
  localparam int YW   = 8;
  localparam int CW   = 3;
  localparam int XMAX = 159;
  localparam int YMAX = 119;

  logic CLK  = 1'b0;
  logic NRST = 1'b0;

  rect_draw_engine_if #(.XW(XW), .YW(YW), .CW(CW)) bus ();

  rect_draw_engine #(.XW(XW), .YW(YW), .CW(CW), .XMAX(XMAX), .YMAX(YMAX)) dut (
    .CLK  (CLK),
    .NRST (NRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int vec_cnt = 0;
  int err_cnt = 0;
  int exp_q[$];

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] obs_word();
    return {6'd0, bus.WE, bus.X, bus.Y, bus.R, bus.G, bus.B};
  endfunction

  function automatic logic [31:0] exp_word(input int x, input int y, input int r, input int g, input int b);
    return 32'((1 << 25) | (x << 17) | (y << 9) | (r << 6) | (g << 3) | b);
  endfunction

  task automatic scramble_cmd();
    bus.MODE = 2'($urandom_range(0, 3));
    bus.X0   = 8'($urandom);
    bus.Y0   = 8'($urandom);
    bus.X1   = 8'($urandom);
    bus.Y1   = 8'($urandom);
    bus.CR   = 3'($urandom);
    bus.CG   = 3'($urandom);
    bus.CB   = 3'($urandom);
  endtask

  // bp: 0 = always ready, 1 = alternate ready/stall, 2 = random stalls.
  // poke: pulse START once mid-scan, which must be ignored.
  task automatic run_cmd(input int mode, input int x0, input int y0, input int x1, input int y1,
                         input int r, input int g, input int b, input int bp, input bit poke);
    int xl, xh, yl, yh, w, h, n, cyc, acc, first_we, last_acc, e, budget;
    bit done_seen, stall_prev, rdy;
    logic [31:0] prev_v, cur_v;

    xl = (x0 < x1) ? x0 : x1;
    xh = (x0 < x1) ? x1 : x0;
    yl = (y0 < y1) ? y0 : y1;
    yh = (y0 < y1) ? y1 : y0;
    if (xl > XMAX) xl = XMAX;
    if (xh > XMAX) xh = XMAX;
    if (yl > YMAX) yl = YMAX;
    if (yh > YMAX) yh = YMAX;
    if (mode == 2) begin
      xl = 0; xh = XMAX; yl = 0; yh = YMAX;
    end
    exp_q.delete();
    if (mode != 3) begin
      for (int y = yl; y <= yh; y++) begin
        for (int x = xl; x <= xh; x++) begin
          if (mode != 1 || x == xl || x == xh || y == yl || y == yh)
            exp_q.push_back(x * 256 + y);
        end
      end
    end
    w = xh - xl + 1;
    h = yh - yl + 1;
    if (mode == 3)      n = 0;
    else if (mode == 1) n = (w >= 2 && h >= 2) ? (2 * w + 2 * h - 4) : w * h;
    else                n = w * h;

    bus.START = 1'b1;
    bus.MODE  = 2'(mode);
    bus.X0    = 8'(x0);
    bus.Y0    = 8'(y0);
    bus.X1    = 8'(x1);
    bus.Y1    = 8'(y1);
    bus.CR    = 3'(r);
    bus.CG    = 3'(g);
    bus.CB    = 3'(b);
    step();
    bus.START = 1'b0;
    scramble_cmd();
    check_value("setup_status", {29'd0, bus.BUSY, bus.WE, bus.DONE}, 32'b100);

    cyc = 1; acc = 0; first_we = -1; last_acc = 0;
    done_seen = 1'b0; stall_prev = 1'b0; prev_v = '0;
    budget = n * 4 + 40;
    while (!done_seen && cyc < budget) begin
      step();
      cyc++;
      bus.START = 1'b0;
      cur_v = obs_word();
      if (stall_prev) check_value("hold", cur_v, prev_v);
      stall_prev = 1'b0;
      if (bp == 0)      rdy = 1'b1;
      else if (bp == 1) rdy = (cyc % 2 == 0);
      else              rdy = ($urandom_range(0, 2) != 0);
      bus.WREADY = rdy;
      if (bus.DONE) begin
        done_seen = 1'b1;
        check_value("done_cycle", 32'(cyc), 32'((n == 0) ? 2 : last_acc + 1));
        check_value("done_status", {30'd0, bus.WE, bus.BUSY}, 32'b01);
      end else if (bus.WE) begin
        if (first_we < 0) begin
          first_we = cyc;
          check_value("first_we", 32'(cyc), 32'd2);
        end
        if (rdy) begin
          if (exp_q.size() == 0) begin
            check_value("extra_pix", 32'(acc + 1), 32'(n));
          end else begin
            e = exp_q.pop_front();
            check_value("pix", cur_v, exp_word(e / 256, e % 256, r, g, b));
          end
          acc++;
          last_acc = cyc;
          if (poke && acc == 1 && n > 4) begin
            bus.START = 1'b1;
            bus.MODE  = 2'b10;
          end
        end else begin
          stall_prev = 1'b1;
          prev_v     = cur_v;
        end
      end
    end
    if (!done_seen) check_value("timeout", 32'd0, 32'd1);
    check_value("count", 32'(acc), 32'(n));
    if (bp == 0 && n > 0) check_value("rate", 32'(last_acc - first_we + 1), 32'(n));
    step();
    bus.WREADY = 1'b1;
    check_value("idle_after", {29'd0, bus.BUSY, bus.DONE, bus.WE}, 32'd0);
    $display("cmd mode=%0d (%0d,%0d)-(%0d,%0d) bp=%0d accepts=%0d expected=%0d", mode, x0, y0, x1, y1, bp, acc, n);
  endtask

  task automatic reset_test();
    int acc;
    int cyc;
    bus.WREADY = 1'b1;
    bus.START  = 1'b1;
    bus.MODE   = 2'b00;
    bus.X0 = 8'd0; bus.Y0 = 8'd0; bus.X1 = 8'd9; bus.Y1 = 8'd9;
    bus.CR = 3'd3; bus.CG = 3'd4; bus.CB = 3'd5;
    step();
    bus.START = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < 3 && cyc < 20) begin
      step();
      cyc++;
      if (bus.WE) acc++;
    end
    check_value("rst_pre_accepts", 32'(acc), 32'd3);
    NRST = 1'b0;
    step();
    check_value("rst_outputs", obs_word(), 32'd0);
    check_value("rst_status", {30'd0, bus.BUSY, bus.DONE}, 32'd0);
    NRST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_value("rst_quiet", {29'd0, bus.WE, bus.BUSY, bus.DONE}, 32'd0);
    end
    $display("reset mid-command after %0d accepts", acc);
  endtask

  initial begin
    int m, x0, y0, x1, y1;
    bus.START  = 1'b0;
    bus.WREADY = 1'b1;
    bus.MODE   = 2'b00;
    bus.X0 = '0; bus.Y0 = '0; bus.X1 = '0; bus.Y1 = '0;
    bus.CR = '0; bus.CG = '0; bus.CB = '0;
    NRST = 1'b0;
    step();
    step();
    check_value("reset_pix", obs_word(), 32'd0);
    check_value("reset_status", {30'd0, bus.BUSY, bus.DONE}, 32'd0);
    NRST = 1'b1;
    step();

    run_cmd(0, 2, 3, 4, 4, 5, 2, 7, 0, 1'b0);
    run_cmd(0, 4, 4, 2, 3, 5, 2, 7, 0, 1'b0);
    run_cmd(1, 0, 0, 3, 3, 6, 1, 3, 0, 1'b0);
    run_cmd(1, 5, 5, 5, 8, 2, 2, 2, 0, 1'b0);
    run_cmd(1, 3, 7, 9, 7, 4, 0, 1, 0, 1'b0);
    run_cmd(0, 2, 3, 4, 4, 5, 2, 7, 1, 1'b1);
    run_cmd(0, 150, 10, 200, 12, 7, 7, 7, 0, 1'b0);
    run_cmd(1, 250, 118, 140, 240, 1, 6, 3, 2, 1'b0);
    run_cmd(2, 9, 9, 9, 9, 1, 1, 1, 0, 1'b0);
    run_cmd(3, 1, 2, 3, 4, 5, 6, 7, 0, 1'b0);
    reset_test();
    run_cmd(0, 0, 0, 9, 9, 3, 4, 5, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      m  = (t % 7 == 6) ? 3 : int'($urandom_range(0, 1));
      x0 = $urandom_range(0, 24);
      x1 = $urandom_range(0, 24);
      y0 = $urandom_range(0, 24);
      y1 = $urandom_range(0, 24);
      if ($urandom_range(0, 4) == 0) begin
        x0 = $urandom_range(140, 255);
        x1 = $urandom_range(140, 255);
      end
      if ($urandom_range(0, 4) == 0) begin
        y0 = $urandom_range(110, 255);
        y1 = $urandom_range(110, 255);
      end
      run_cmd(m, x0, y0, x1, y1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
